// File: rtl/crc32_tx_append.sv
// Appends a CRC-32 word (poly 0x04C11DB7, init all-ones, unreflected, no final XOR) after each frame.
// Optional build macro CRC32_TX_ERRINJ_EN lets err_inj corrupt bit 0 of the appended CRC word.
module crc32_tx_append (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last,
  output logic        m_is_crc,
  output logic [15:0] frames_sent,
  input  logic        err_inj
);

  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  typedef enum logic {PASS, APPEND} state_t;

  state_t      state;
  logic [31:0] crc;
  logic [31:0] crc_word;
  logic        slot_free;
  logic        accept;

  // One 32-bit update: fold the word into the register, then clock the LFSR 32 times.
  function automatic logic [31:0] crc32_step(input logic [31:0] c, input logic [31:0] w);
    logic [31:0] r;
    r = c ^ w;
    for (int i = 0; i < 32; i++) begin
      r = r[31] ? ((r << 1) ^ CRC_POLY) : (r << 1);
    end
    return r;
  endfunction

  assign slot_free = !m_valid || m_ready;
  assign s_ready   = rst_n && (state == PASS) && slot_free;
  assign accept    = s_valid && s_ready;

`ifdef CRC32_TX_ERRINJ_EN
  assign crc_word = crc ^ {31'b0, err_inj};
`else
  logic unused_err_inj;
  assign unused_err_inj = err_inj;
  assign crc_word       = crc;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= PASS;
      crc         <= CRC_INIT;
      m_valid     <= 1'b0;
      m_data      <= 32'h0;
      m_last      <= 1'b0;
      m_is_crc    <= 1'b0;
      frames_sent <= 16'h0;
    end else begin
      case (state)
        PASS: begin
          if (accept) begin
            m_data   <= s_data;
            m_valid  <= 1'b1;
            m_last   <= 1'b0;
            m_is_crc <= 1'b0;
            crc      <= crc32_step(crc, s_data);
            if (s_last) state <= APPEND;
          end else if (slot_free) begin
            m_valid <= 1'b0;
          end
        end
        APPEND: begin
          // The CRC word goes out the same cycle the last payload word leaves.
          if (slot_free) begin
            m_data      <= crc_word;
            m_valid     <= 1'b1;
            m_last      <= 1'b1;
            m_is_crc    <= 1'b1;
            crc         <= CRC_INIT;
            frames_sent <= frames_sent + 16'd1;
            state       <= PASS;
          end
        end
        default: state <= PASS;
      endcase
    end
  end

endmodule

// File: tb/tb_crc32_tx_append.sv
// Scoreboard bench for crc32_tx_append: randomized frames checked against a bit-serial CRC-32 model.
module tb_crc32_tx_append;

  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = 32'h0;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [31:0] m_data;
  logic        m_last;
  logic        m_is_crc;
  logic [15:0] frames_sent;
  logic        err_inj = 1'b0;

  crc32_tx_append dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .m_is_crc(m_is_crc), .frames_sent(frames_sent), .err_inj(err_inj)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        is_crc;
    logic        inj;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] cur_frame[$];
  logic [31:0] out_words[$];
  logic [15:0] model_frames = 16'h0;
  int          checks = 0;
  int          errors = 0;
  int          rdy_mode = 0;      // 0: always ready, 1: random, 2: forced_ready
  logic        forced_ready = 1'b1;

  // Reference: CRC of the frame as one MSB-first bit stream through a serial LFSR.
  function automatic logic [31:0] ref_crc(input logic [31:0] ws[$]);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (ws[i]) begin
      for (int b = 31; b >= 0; b--) begin
        fb = c[31] ^ ws[i][b];
        c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
      end
    end
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream ready generator, updated just after each rising edge.
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = forced_ready;
    endcase
  end

  // Monitor: compares every handshaken output word against the scoreboard.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = 32'h0;
  logic [1:0]  prev_tag = 2'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", m_data, prev_data);
        chk("hold_tag", 32'({m_last, m_is_crc}), 32'(prev_tag));
      end
      if (m_valid && !m_ready) chk("stall_s_ready", 32'(s_ready), 32'd0);
      if (m_valid && m_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h, expected no word at %0t", m_data, $time);
        end else begin
          e = expq.pop_front();
          chk("out_data", m_data, e.data);
          chk("out_tag", 32'({m_last, m_is_crc}), 32'({e.last, e.is_crc}));
          out_words.push_back(m_data);
          if (m_last) begin
            if (!e.inj) chk("residue", ref_crc(out_words), 32'h0);
            out_words.delete();
            model_frames = model_frames + 16'd1;
            chk("frames_sent", 32'(frames_sent), 32'(model_frames));
          end
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_tag   = {m_last, m_is_crc};
    end
  end

  task automatic send_word(input logic [31:0] d, input logic l);
    logic [31:0] c;
    logic        inj;
    int          t;
    t = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      t++;
      if (t > 300) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got s_ready=0, expected 1 within 300 cycles");
        break;
      end
    end
    expq.push_back('{data: d, last: 1'b0, is_crc: 1'b0, inj: 1'b0});
    cur_frame.push_back(d);
    if (l) begin
      c = ref_crc(cur_frame);
`ifdef CRC32_TX_ERRINJ_EN
      inj = err_inj;
`else
      inj = 1'b0;
`endif
      expq.push_back('{data: c ^ {31'b0, inj}, last: 1'b1, is_crc: 1'b1, inj: inj});
      cur_frame.delete();
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = $urandom;
    if (l) begin
      @(negedge clk);
      chk("append_s_ready", 32'(s_ready), 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rand_frame(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_word($urandom, 1'(i == n - 1));
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((expq.size() != 0 || m_valid) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d words pending, expected 0", expq.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_s_ready", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1;
    expq.delete();
    cur_frame.delete();
    out_words.delete();
    model_frames = 16'h0;
    @(negedge clk);
    chk("reset_m_valid", 32'(m_valid), 32'd0);
    chk("reset_m_data", m_data, 32'h0);
    chk("reset_tags", 32'({m_last, m_is_crc}), 32'd0);
    chk("reset_frames_sent", 32'(frames_sent), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int run;
    int t;
    do_reset();

    // Single all-ones word: CRC register collapses to zero.
    send_word(32'hFFFFFFFF, 1'b1);
    wait_drain();
    chk("single_frames_sent", 32'(frames_sent), 32'd1);

    send_word(32'hFFFFFFFF, 1'b0);
    send_word(32'h00000000, 1'b1);
    wait_drain();
    rand_frame(8, 1'b0);
    wait_drain();

    // Stall 3 cycles on payload word 2 and again on the CRC word.
    rdy_mode = 2;
    forced_ready = 1'b1;
    send_word($urandom, 1'b0);
    send_word($urandom, 1'b0);
    forced_ready = 1'b0;
    fork
      send_word($urandom, 1'b0);
      begin repeat (3) @(posedge clk); #1; forced_ready = 1'b1; end
    join
    send_word($urandom, 1'b1);
    forced_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    forced_ready = 1'b1;
    wait_drain();
    rdy_mode = 0;

    // Two back-to-back 4-word frames fill exactly 10 consecutive output cycles.
    fork
      begin rand_frame(4, 1'b0); rand_frame(4, 1'b0); end
      begin
        t = 0;
        do begin @(negedge clk); t++; end while (!m_valid && t < 100);
        run = 0;
        while (m_valid && run < 50) begin run++; @(negedge clk); end
        chk("b2b_cycles", 32'(run), 32'd10);
      end
    join
    wait_drain();

    rdy_mode = 1;
    for (int f = 0; f < 20; f++) begin
      err_inj = 1'($urandom_range(0, 1));
      rand_frame($urandom_range(1, 8), 1'b1);
      wait_drain();
      err_inj = 1'b0;
    end
    rdy_mode = 0;

    // Reset in the middle of a frame discards it without a CRC word.
    send_word($urandom, 1'b0);
    send_word($urandom, 1'b0);
    do_reset();
    rand_frame(4, 1'b0);
    wait_drain();
    chk("post_reset_frames_sent", 32'(frames_sent), 32'd1);

`ifdef CRC32_TX_ERRINJ_EN
    err_inj = 1'b1;
    send_word(32'hFFFFFFFF, 1'b1);
    wait_drain();
    err_inj = 1'b0;
    rand_frame(3, 1'b0);
    wait_drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected end before 2ms");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/crc32_tx_append.md
CRC32_TX_APPEND -- requirements
Module: crc32_tx_append

Interface
REQ-001 SHALL have: clk  input  1  clock; all logic on rising edge.
REQ-002 SHALL have: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have: s_valid  input  1  upstream data word valid.
REQ-004 SHALL have: s_ready  output  1  block accepts s_data this cycle.
REQ-005 SHALL have: s_data  input  32  frame payload word.
REQ-006 SHALL have: s_last  input  1  s_data is final payload word of frame.
REQ-007 SHALL have: m_valid  output  1  m_data valid.
REQ-008 SHALL have: m_ready  input  1  downstream accepts m_data.
REQ-009 SHALL have: m_data  output  32  payload word or appended CRC word.
REQ-010 SHALL have: m_last  output  1  m_data is final word of frame (the CRC word).
REQ-011 SHALL have: m_is_crc  output  1  m_data is the appended CRC word.
REQ-012 SHALL have: frames_sent  output  16  count of CRC words handed off, wraps 0xFFFF->0x0000.
REQ-013 SHALL have: err_inj  input  1  corrupt next CRC word (only with CRC32_TX_ERRINJ_EN).

Function
REQ-014 SHALL use CRC-32 polynomial 0x04C11DB7, 32 bits per update, init 0xFFFFFFFF, no reflection, no final XOR: crc_next = M*(crc XOR word), M the linear 32-bit-per-clock CRC-32 matrix.
REQ-015 SHALL append as CRC word the running crc register value unmodified, so a CRC-32 checker updating over payload+CRC word ends with residue 0x00000000.
REQ-016 SHALL implement FSM states PASS and APPEND; reset state PASS.
REQ-017 Handshake: transfer on valid&&ready; m_valid SHALL stay high and m_data/m_last/m_is_crc stable until m_ready.
REQ-018 Output slot free: slot_free = !m_valid || m_ready.
REQ-019 PASS: s_ready = slot_free; on s_valid&&s_ready load m_data<=s_data, m_valid<=1, m_last<=0, m_is_crc<=0, crc<=crc_next; if s_last go APPEND.
REQ-020 APPEND: s_ready=0; when slot_free load m_data<=crc, m_valid<=1, m_last<=1, m_is_crc<=1, crc<=0xFFFFFFFF, frames_sent+=1, go PASS.
REQ-021 PASS with slot_free and no accepted input: m_valid<=0.
REQ-022 Latency: payload word on m_data 1 cycle after acceptance; CRC word loaded in cycle last payload word handshakes out (m_ready=1), no bubble.
REQ-023 Throughput: N-word frame occupies N+1 output cycles with s_valid, m_ready held high; next frame's first word accepted the cycle the CRC word is loaded is NOT allowed (s_ready=0 in APPEND).
REQ-024 Single-word frame (s_valid, s_last together on first word) SHALL produce 2 output words; empty frames unsupported.
REQ-025 s_last ignored when s_valid=0 or s_ready=0.

Reset
REQ-026 On rst_n=0 at clk edge: state PASS, crc 0xFFFFFFFF, m_valid 0, m_data 0, m_last 0, m_is_crc 0, frames_sent 0; s_ready 0 during reset cycle.
REQ-027 Reset mid-frame SHALL discard partial frame and pending output word with no CRC emitted.

Configuration
REQ-028 Macro CRC32_TX_ERRINJ_EN defined: err_inj sampled at CRC-word load; if 1, appended word = crc XOR 0x00000001 (checker residue nonzero); crc register and frames_sent unaffected.
REQ-029 Macro undefined: err_inj port present but ignored; appended word always per REQ-015.

Verification
REQ-030 Single word 0xFFFFFFFF with s_last, m_ready=1 -> outputs 0xFFFFFFFF then 0x00000000 with m_last=m_is_crc=1; frames_sent=1.
REQ-031 Frame {0xFFFFFFFF, 0x00000000} -> CRC word 0x00000000; 8 random words -> CRC-32 checker over 9 output words yields residue 0x00000000.
REQ-032 m_ready low 3 cycles during payload word 2 and during CRC word -> m_data held stable, no loss, s_ready=0 while stalled.
REQ-033 Two back-to-back 4-word frames, continuous ready -> 10 output cycles, second frame CRC independent of first (init restored).
REQ-034 rst_n low after 2 of 4 words -> m_valid=0 next cycle, frames_sent=0, following frame CRC correct.
REQ-035 CRC32_TX_ERRINJ_EN defined, err_inj=1 at CRC load for frame {0xFFFFFFFF} -> CRC word 0x00000001; next frame CRC correct.
